// File: rtl/clint_mh_pkg.sv
// Shared CLINT definitions: register offsets, response codes, FSM states and
// the address decoder / byte-merge helpers used by the top and the mtime counter.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [2:0] hart;
        logic       hi;
    } reg_sel_t;

    // Misaligned, out-of-region and absent-hart addresses all map to REG_NONE.
    function automatic reg_sel_t decode(input logic [31:0] addr,
                                        input logic [15:0] base_hi,
                                        input int unsigned num_harts);
        reg_sel_t   sel;
        logic [15:0] off;
        sel.kind = REG_NONE;
        sel.hart = '0;
        sel.hi   = 1'b0;
        off      = addr[15:0];
        if (addr[31:16] == base_hi && off[1:0] == 2'b00) begin
            if (off[15:5] == MSIP_OFF[15:5]) begin
                sel.hart = off[4:2];
                if (32'(off[4:2]) < num_harts) sel.kind = REG_MSIP;
            end else if (off[15:6] == MTIMECMP_OFF[15:6]) begin
                sel.hart = off[5:3];
                sel.hi   = off[2];
                if (32'(off[5:3]) < num_harts) sel.kind = REG_MTIMECMP;
            end else if (off[15:3] == MTIME_OFF[15:3]) begin
                sel.hi   = off[2];
                sel.kind = REG_MTIME;
            end
        end
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mh_if.sv
// AXI4-Lite bus bundle (32-bit address/data) with master and slave views.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/clint_mtime_counter.sv
// Tick prescaler plus free-running 64-bit mtime with a byte-strobed,
// half-selected write port that overrides the tick in the cycle it is used.
module clint_mtime_counter
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic [63:0] mtime,
    output logic        tick
);

    logic [15:0] presc;
    logic [31:0] merged;

    assign tick = (presc == 16'(PRESCALE - 1));

    always_comb begin
        merged = merge_bytes(wr_hi ? mtime[63:32] : mtime[31:0], wr_data, wr_strb);
    end

    // The prescaler keeps running across mtime writes; only the increment is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (wr_en) begin
                if (wr_hi) mtime[63:32] <= merged;
                else       mtime[31:0]  <= merged;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: AXI4-Lite decode, independent read/write FSMs, msip and
// mtimecmp banks and registered interrupt outputs. Define CLINT_MTIME_WRITE_EN
// to make mtime writable; otherwise mtime writes complete with SLVERR.
module clint_mh
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'ha000_0000,
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    axi_lite_if.slave            s,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] msip
);

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q;
    logic [63:0]          mtime;

    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    reg_sel_t    rd_sel, wr_sel;
    logic [31:0] rd_val, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        rd_err, wr_err, wr_commit, mtime_wr;
    logic        ar_hs, aw_hs, w_hs;

    assign ar_hs = s.arvalid && s.arready;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next   = rd_state;
        s.arready = 1'b0;
        s.rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                s.arready = 1'b1;
                if (s.arvalid) rd_next = RD_RESP;
            end
            RD_RESP: begin
                s.rvalid = 1'b1;
                if (s.rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_next   = wr_state;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        wr_commit = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s.awready = 1'b1;
                s.wready  = 1'b1;
                if (s.awvalid && s.wvalid) begin
                    wr_commit = 1'b1;
                    wr_next   = WR_RESP;
                end else if (s.awvalid) begin
                    wr_next = WR_WAIT_W;
                end else if (s.wvalid) begin
                    wr_next = WR_WAIT_AW;
                end
            end
            WR_WAIT_W: begin
                s.wready = 1'b1;
                if (s.wvalid) begin
                    wr_commit = 1'b1;
                    wr_next   = WR_RESP;
                end
            end
            WR_WAIT_AW: begin
                s.awready = 1'b1;
                if (s.awvalid) begin
                    wr_commit = 1'b1;
                    wr_next   = WR_RESP;
                end
            end
            WR_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_sel = decode(s.araddr, BASE_ADDR[31:16], NUM_HARTS);
        rd_err = (rd_sel.kind == REG_NONE);
        rd_val = '0;
        case (rd_sel.kind)
            REG_MSIP: begin
                for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                    if (rd_sel.hart == 3'(h)) rd_val = {31'b0, msip_q[h]};
                end
            end
            REG_MTIMECMP: begin
                for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                    if (rd_sel.hart == 3'(h))
                        rd_val = rd_sel.hi ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
                end
            end
            REG_MTIME: rd_val = rd_sel.hi ? mtime[63:32] : mtime[31:0];
            default:   rd_val = '0;
        endcase
    end

    // Whichever half of the AW/W pair arrived first comes from the holding registers.
    always_comb begin
        wr_addr = (wr_state == WR_WAIT_W)  ? aw_addr_q : s.awaddr;
        wr_data = (wr_state == WR_WAIT_AW) ? w_data_q  : s.wdata;
        wr_strb = (wr_state == WR_WAIT_AW) ? w_strb_q  : s.wstrb;
        wr_sel  = decode(wr_addr, BASE_ADDR[31:16], NUM_HARTS);
`ifdef CLINT_MTIME_WRITE_EN
        wr_err  = (wr_sel.kind == REG_NONE);
`else
        wr_err  = (wr_sel.kind == REG_NONE) || (wr_sel.kind == REG_MTIME);
`endif
        mtime_wr = wr_commit && !wr_err && (wr_sel.kind == REG_MTIME) && (wr_strb != 4'b0000);
    end

    clint_mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mtime_wr),
        .wr_hi   (wr_sel.hi),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .mtime   (mtime),
        .tick    ()
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            msip_q    <= '0;
            mtip      <= '0;
            msip      <= '0;
            s.rdata   <= '0;
            s.rresp   <= RESP_OKAY;
            s.bresp   <= RESP_OKAY;
            for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
        end else begin
            if (aw_hs) aw_addr_q <= s.awaddr;
            if (w_hs) begin
                w_data_q <= s.wdata;
                w_strb_q <= s.wstrb;
            end
            if (ar_hs) begin
                s.rdata <= rd_err ? '0 : rd_val;
                s.rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (wr_commit) begin
                s.bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
                for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                    if (!wr_err && wr_sel.hart == 3'(h)) begin
                        if (wr_sel.kind == REG_MSIP && wr_strb[0]) msip_q[h] <= wr_data[0];
                        if (wr_sel.kind == REG_MTIMECMP) begin
                            if (wr_sel.hi)
                                mtimecmp_q[h][63:32] <= merge_bytes(mtimecmp_q[h][63:32], wr_data, wr_strb);
                            else
                                mtimecmp_q[h][31:0]  <= merge_bytes(mtimecmp_q[h][31:0], wr_data, wr_strb);
                        end
                    end
                end
            end
            for (int unsigned h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime >= mtimecmp_q[h]);
            msip <= msip_q;
        end
    end

endmodule
